// File: rtl/adc_pkg.sv
// Shared definitions for the multi-lane ADC averager: FSM encoding,
// default-configuration widths and a lane-index width helper.
package adc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_SCALE = 2'd2,
    ST_EMIT  = 2'd3
  } state_t;

  // Widths for the default configuration (12-bit ADC, 2**10 samples, Q16.48, 4 lanes).
  localparam int ACC_W = 12 + 10;
  localparam int FRAC  = 64 - 16;
  localparam int CH_W  = 2;

  // Lane tag width; a single-lane build still carries a 1-bit tag.
  function automatic int ch_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/adc_scale_mult.sv
// Shared scaler: average times fixed-point gain, post-shift and saturate.
module adc_scale_mult #(
  parameter int AVG_W      = 22,
  parameter int FP_WIDTH   = 64,
  parameter int FRAC       = 48,
  parameter int GAIN_SHIFT = 11
) (
  input  logic [AVG_W-1:0]    avg,
  input  logic [FP_WIDTH-1:0] gain,
  output logic [FP_WIDTH-1:0] res,
  output logic                sat
);

  localparam int PW = AVG_W + FRAC + FP_WIDTH;

  logic [PW-1:0] prod;
  logic [PW-1:0] shf;

  // The average is promoted to the gain's fixed-point format before the
  // multiply; the FRAC zero bits fall straight back out of the shift, so
  // synthesis only builds an AVG_W x FP_WIDTH multiplier.
  assign prod = (PW'(avg) << FRAC) * PW'(gain);
  assign shf  = prod >> (FRAC + GAIN_SHIFT);
  assign sat  = |shf[PW-1:FP_WIDTH];
  assign res  = sat ? '1 : shf[FP_WIDTH-1:0];

endmodule

// File: rtl/adc_multi_avg.sv
// Multi-lane ADC averager: accumulate 2**LOG2_SAMPS samples per lane, then
// scale each lane average by its gain and stream the results out one lane
// at a time with a channel tag.
module adc_multi_avg
  import adc_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int ADC_WIDTH  = 12,
  parameter int LOG2_SAMPS = 10,
  parameter int FP_WIDTH   = 64,
  parameter int INT_WIDTH  = 16,
  parameter int GAIN_SHIFT = 11
) (
  input  logic                          ADC_CLK,
  input  logic                          RST,
  input  logic                          enable,
  input  logic                          continuous,
  input  logic                          ADC_VALID,
  input  logic [NUM_CH*ADC_WIDTH-1:0]   ADC_DATA_IN,
  input  logic [NUM_CH*FP_WIDTH-1:0]    GAIN_IN,
  output logic [FP_WIDTH-1:0]           OUT_DATA,
  output logic [ch_width(NUM_CH)-1:0]   OUT_CH,
  output logic                          OUT_VALID,
  input  logic                          OUT_READY,
  output logic                          BUSY,
  output logic                          DONE,
  output logic                          SAT
);

  localparam int AW = ADC_WIDTH + LOG2_SAMPS;
  localparam int FW = FP_WIDTH - INT_WIDTH;
  localparam int CW = ch_width(NUM_CH);

  state_t                           state;
  logic [LOG2_SAMPS-1:0]            cnt;
  logic [CW-1:0]                    lane;
  logic                             cont_q;
  logic [NUM_CH-1:0][FP_WIDTH-1:0]  gain_q;
  logic [NUM_CH-1:0][AW-1:0]        acc;
  logic                             hs, last_lane, acc_en, acc_clr;
  logic [AW-1:0]                    avg;
  logic [FP_WIDTH-1:0]              res;
  logic                             res_sat;

  // Handshake, frame-start clear and lane-select decode.
  always_comb begin
    hs        = OUT_VALID & OUT_READY;
    last_lane = (lane == CW'(NUM_CH - 1));
    acc_en    = (state == ST_ACCUM) && enable && ADC_VALID;
    acc_clr   = ((state == ST_IDLE) && enable) ||
                ((state == ST_EMIT) && hs && last_lane && cont_q && enable);
    avg       = acc[lane] >> LOG2_SAMPS;
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    logic [AW-1:0] acc_r;
    // Per-lane accumulator; wide enough that a full frame never wraps.
    always_ff @(posedge ADC_CLK) begin
      if (RST || acc_clr) acc_r <= '0;
      else if (acc_en)    acc_r <= acc_r + AW'(ADC_DATA_IN[k*ADC_WIDTH +: ADC_WIDTH]);
    end
    assign acc[k] = acc_r;
  end

  adc_scale_mult #(
    .AVG_W(AW), .FP_WIDTH(FP_WIDTH), .FRAC(FW), .GAIN_SHIFT(GAIN_SHIFT)
  ) u_mult (
    .avg(avg), .gain(gain_q[lane]), .res(res), .sat(res_sat)
  );

  assign BUSY = (state != ST_IDLE);

  // Frame sequencing with registered stream outputs.
  always_ff @(posedge ADC_CLK) begin
    if (RST) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      lane      <= '0;
      cont_q    <= 1'b0;
      gain_q    <= '0;
      OUT_DATA  <= '0;
      OUT_CH    <= '0;
      OUT_VALID <= 1'b0;
      DONE      <= 1'b0;
      SAT       <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        ST_IDLE: if (enable) begin
          state  <= ST_ACCUM;
          cnt    <= '0;
          lane   <= '0;
          SAT    <= 1'b0;
          gain_q <= GAIN_IN;
          cont_q <= continuous;
        end
        ST_ACCUM: begin
          if (!enable) state <= ST_IDLE;
          else if (ADC_VALID) begin
            cnt <= cnt + 1'b1;
            if (&cnt) begin
              state <= ST_SCALE;
              lane  <= '0;
            end
          end
        end
        ST_SCALE: begin
          if (!enable) state <= ST_IDLE;
          else begin
            OUT_DATA  <= res;
            OUT_CH    <= lane;
            OUT_VALID <= 1'b1;
            if (res_sat) SAT <= 1'b1;
            state     <= ST_EMIT;
          end
        end
        ST_EMIT: if (hs) begin
          OUT_VALID <= 1'b0;
          if (last_lane) begin
            DONE <= 1'b1;
            // Re-arm in place so continuous mode loses no cycle in IDLE.
            if (cont_q && enable) begin
              state  <= ST_ACCUM;
              cnt    <= '0;
              lane   <= '0;
              SAT    <= 1'b0;
              gain_q <= GAIN_IN;
              cont_q <= continuous;
            end else begin
              state <= ST_IDLE;
            end
          end else if (!enable) begin
            state <= ST_IDLE;
          end else begin
            lane  <= lane + 1'b1;
            state <= ST_SCALE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
